weight_stream_ctrl: RTL and testbench

// - Sequences one parameter ROM (registered read, ROM_LATENCY cycles, ce0 tied high) into a valid/ready weight stream.
// - Plays the tensor NUM_PASSES times per start command.
// - Tracks in-flight reads and buffers returned words, so backpressure never drops or duplicates a word.
// - Sits between a *_weight ROM wrapper and a linear/matmul core; replaces the free-running always-valid source.

---
 rtl/weight_stream_pkg.sv | 25 ++
 rtl/weight_stream_fifo.sv | 86 ++++++++
 rtl/weight_stream_ctrl.sv | 178 +++++++++++++++++
 tb/tb_weight_stream_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/weight_stream_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : weight_stream_pkg                                               |
// | Purpose  : Shared types and helpers for the weight stream controller.      |
// |            - ws_state_t    : controller FSM state encoding                 |
// |            - ws_addr_width : ROM address width for a given word depth      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package weight_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } ws_state_t;

  // One spare bit over the minimum so OUT_DEPTH values that are exact powers
  // of two still have headroom for the address register.
  function automatic int ws_addr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/weight_stream_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : weight_stream_fifo                                              |
// | Purpose  : Small synchronous FIFO buffering ROM words for the output       |
// |            stream. Head word is presented combinationally on dout and     |
// |            stays stable until popped.                                      |
// | Ports    : clk, rst        - clock, synchronous active-high reset          |
// |            push, din       - write a word                                  |
// |            pop, dout       - read / head word                              |
// |            count, empty,   - occupancy status                              |
// |            full                                                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module weight_stream_fifo #(
  parameter  int DWIDTH     = 64,
  parameter  int FIFO_DEPTH = 4,
  localparam int CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DWIDTH-1:0] din,
  output logic [DWIDTH-1:0] dout,
  output logic [CW-1:0]     count,
  output logic              empty,
  output logic              full
);

  localparam int c_pw = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [DWIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [c_pw-1:0]   r_wr_ptr;
  logic [c_pw-1:0]   r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              w_push;
  logic              w_pop;

  assign empty = (r_count == '0);
  assign full  = (r_count == CW'(FIFO_DEPTH));
  assign count = r_count;
  assign dout  = r_mem[r_rd_ptr];

  // A push into a full FIFO is only legal when a pop frees the slot in the
  // same cycle; anything else is dropped here and flagged below.
  assign w_push = push && (!full || pop);
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == c_pw'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_pw'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && full && !pop))
        else $error("weight_stream_fifo: push while full, word lost");
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/weight_stream_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : weight_stream_ctrl                                              |
// | Purpose  : Streams a parameter ROM (registered read, ROM_LATENCY cycles)   |
// |            out as a valid/ready weight stream, NUM_PASSES times per start. |
// |            Reads are credit-limited against the output FIFO so that       |
// |            backpressure never drops or duplicates a word.                  |
// | Ports    : clk, rst           - clock, synchronous active-high reset       |
// |            start, num_passes  - run command (sampled in IDLE)              |
// |            busy, done         - run status / end-of-run pulse              |
// |            rom_addr, rom_ce,  - ROM address0 / ce0 / q0                    |
// |            rom_q                                                           |
// |            data_out[P],       - unpacked weight beat and handshake         |
// |            data_out_valid,                                                 |
// |            data_out_ready                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module weight_stream_ctrl
  import weight_stream_pkg::*;
#(
  parameter  int WEIGHT_PRECISION_0       = 16,
  parameter  int WEIGHT_PARALLELISM_DIM_0 = 4,
  parameter  int WEIGHT_PARALLELISM_DIM_1 = 1,
  parameter  int OUT_DEPTH                = 8,
  parameter  int ROM_LATENCY              = 2,
  parameter  int FIFO_DEPTH               = 4,
  parameter  int PASS_WIDTH               = 8,
  localparam int P      = WEIGHT_PARALLELISM_DIM_0 * WEIGHT_PARALLELISM_DIM_1,
  localparam int DWIDTH = WEIGHT_PRECISION_0 * P,
  localparam int AWIDTH = ws_addr_width(OUT_DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [PASS_WIDTH-1:0]         num_passes,
  output logic                          busy,
  output logic                          done,
  output logic [AWIDTH-1:0]             rom_addr,
  output logic                          rom_ce,
  input  logic [DWIDTH-1:0]             rom_q,
  output logic [WEIGHT_PRECISION_0-1:0] data_out [P],
  output logic                          data_out_valid,
  input  logic                          data_out_ready
);

  localparam int c_cw = $clog2(FIFO_DEPTH + 1);
  localparam int c_iw = $clog2(ROM_LATENCY + 1);

  ws_state_t             r_state;
  logic                  r_busy;
  logic                  r_done;
  logic [AWIDTH-1:0]     r_rom_addr;
  logic [PASS_WIDTH-1:0] r_num_passes;
  logic [PASS_WIDTH-1:0] r_pass_cnt;
  // Bit 0 is the read issued last cycle; the top bit marks the read whose
  // data is on rom_q this cycle.
  logic [ROM_LATENCY-1:0] r_vpipe;

  logic [c_iw-1:0]   w_inflight;
  logic [c_cw-1:0]   w_fifo_count;
  logic              w_fifo_empty;
  logic              w_fifo_full;
  logic [DWIDTH-1:0] w_fifo_dout;
  logic              w_credit;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  logic              w_last_addr;
  logic              w_last_pass;
  logic              w_drained;

  assign rom_ce         = 1'b1;
  assign rom_addr       = r_rom_addr;
  assign busy           = r_busy;
  assign done           = r_done;
  assign data_out_valid = !w_fifo_empty;

  // Number of reads whose data has not yet landed in the FIFO.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < ROM_LATENCY; i++) begin
      w_inflight = w_inflight + c_iw'(r_vpipe[i]);
    end
  end

  // Every issued read owns a FIFO slot from the moment it is issued, so the
  // returning word always has somewhere to go regardless of backpressure.
  assign w_credit    = ((int'(w_fifo_count) + int'(w_inflight)) < FIFO_DEPTH) && !w_fifo_full;
  assign w_issue     = (r_state == ISSUE) && w_credit;
  assign w_push      = r_vpipe[ROM_LATENCY-1];
  assign w_pop       = data_out_valid && data_out_ready;
  assign w_last_addr = (r_rom_addr == AWIDTH'(OUT_DEPTH - 1));
  assign w_last_pass = (r_pass_cnt == (r_num_passes - 1'b1));

  // The run is over once nothing is in flight and the last buffered beat is
  // either gone or being accepted this very cycle.
  assign w_drained = (r_vpipe == '0) &&
                     (w_fifo_empty || ((w_fifo_count == c_cw'(1)) && w_pop));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_rom_addr   <= '0;
      r_num_passes <= '0;
      r_pass_cnt   <= '0;
      r_vpipe      <= '0;
    end else begin
      r_vpipe <= (r_vpipe << 1) | ROM_LATENCY'(w_issue);
      r_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_num_passes <= num_passes;
            r_pass_cnt   <= '0;
            r_rom_addr   <= '0;
            if (num_passes == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ISSUE;
              r_busy  <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (w_issue) begin
            if (w_last_addr) begin
              r_rom_addr <= '0;
              r_pass_cnt <= r_pass_cnt + 1'b1;
              if (w_last_pass) begin
                r_state <= DRAIN;
              end
            end else begin
              r_rom_addr <= r_rom_addr + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (w_drained) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  weight_stream_fifo #(
    .DWIDTH     (DWIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (rom_q),
    .dout  (w_fifo_dout),
    .count (w_fifo_count),
    .empty (w_fifo_empty),
    .full  (w_fifo_full)
  );

  for (genvar j = 0; j < P; j++) begin : g_unpack
    assign data_out[j] = w_fifo_dout[WEIGHT_PRECISION_0*j +: WEIGHT_PRECISION_0];
  end

endmodule
`default_nettype wire

// File: tb/tb_weight_stream_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_weight_stream_ctrl                                           |
// | Purpose  : Directed self-checking bench for weight_stream_ctrl. A two-     |
// |            stage registered ROM model returns word i with element j equal |
// |            to j*256 + i, so element 0 carries the address and element 3   |
// |            checks the unpacking.                                           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_weight_stream_ctrl;

  localparam int PREC = 16;
  localparam int P    = 4;
  localparam int DW   = PREC * P;
  localparam int AW   = 4;
  localparam int OD   = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [7:0]       num_passes;
  logic             busy;
  logic             done;
  logic [AW-1:0]    rom_addr;
  logic             rom_ce;
  logic [DW-1:0]    rom_q;
  logic [DW-1:0]    rom_s1;
  logic [PREC-1:0]  data_out [P];
  logic             data_out_valid;
  logic             data_out_ready;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  weight_stream_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .num_passes     (num_passes),
    .busy           (busy),
    .done           (done),
    .rom_addr       (rom_addr),
    .rom_ce         (rom_ce),
    .rom_q          (rom_q),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready)
  );

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    logic [DW-1:0] w;
    for (int j = 0; j < P; j++) begin
      w[PREC*j +: PREC] = PREC'(j * 256) + PREC'(a);
    end
    return w;
  endfunction

  // Registered ROM with two cycles from address to q.
  always_ff @(posedge clk) begin
    rom_s1 <= rom_word(rom_addr);
    rom_q  <= rom_s1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Drives ready per mode (0: always 1, 1: random, 2: low for 20 cycles then
  // high) and checks every cycle that the head beat is the next expected word.
  task automatic collect(input string tag, input int n_beats, input int mode,
                         input int budget, output int ticks);
    int k;
    k     = 0;
    ticks = 0;
    while (k < n_beats && ticks < budget) begin
      case (mode)
        0:       data_out_ready = 1'b1;
        1:       data_out_ready = 1'($urandom_range(0, 1));
        default: data_out_ready = (ticks >= 20);
      endcase
      if (mode == 2 && ticks == 19) begin
        chk({tag, " reads issued while stalled"}, 64'(rom_addr), 64'd4);
        chk({tag, " valid held while stalled"}, 64'(data_out_valid), 64'd1);
      end
      if (data_out_valid) begin
        chk($sformatf("%s beat %0d elem0", tag, k), 64'(data_out[0]), 64'(k % OD));
        if (data_out_ready) begin
          chk($sformatf("%s beat %0d elem3", tag, k), 64'(data_out[3]),
              64'(16'h0300 + 16'(k % OD)));
          k++;
        end
      end
      tick();
      ticks++;
    end
    chk({tag, " beat count"}, 64'(k), 64'(n_beats));
  endtask

  task automatic wait_done(input string tag, input int budget);
    int t;
    t = 0;
    while (!done && t < budget) begin
      tick();
      t++;
    end
    chk(tag, 64'(done), 64'd1);
  endtask

  initial begin
    int t;
    rst            = 1'b1;
    start          = 1'b0;
    num_passes     = 8'd0;
    data_out_ready = 1'b0;
    repeat (3) tick();
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset valid", 64'(data_out_valid), 64'd0);
    chk("reset rom_addr", 64'(rom_addr), 64'd0);
    chk("rom_ce", 64'(rom_ce), 64'd1);
    rst = 1'b0;
    tick();

    // T1: one pass, ready high, first beat at c4, done right after last pop.
    start = 1'b1; num_passes = 8'd1; data_out_ready = 1'b1;   // c0
    tick(); start = 1'b0;                                      // c1
    chk("T1 busy c1", 64'(busy), 64'd1);
    chk("T1 rom_addr c1", 64'(rom_addr), 64'd0);
    tick();                                                    // c2
    chk("T1 rom_addr c2", 64'(rom_addr), 64'd1);
    tick();                                                    // c3
    chk("T1 valid c3", 64'(data_out_valid), 64'd0);
    tick();                                                    // c4
    for (int i = 0; i < OD; i++) begin
      chk($sformatf("T1 valid beat %0d", i), 64'(data_out_valid), 64'd1);
      chk($sformatf("T1 elem0 beat %0d", i), 64'(data_out[0]), 64'(i));
      chk($sformatf("T1 elem3 beat %0d", i), 64'(data_out[3]), 64'(16'h0300 + 16'(i)));
      tick();
    end                                                        // c12
    chk("T1 done c12", 64'(done), 64'd1);
    chk("T1 busy c12", 64'(busy), 64'd0);
    chk("T1 valid c12", 64'(data_out_valid), 64'd0);
    tick();
    chk("T1 done c13", 64'(done), 64'd0);

    // T2: three passes back to back, 24 beats at c4..c27, done at c28.
    start = 1'b1; num_passes = 8'd3;
    tick(); start = 1'b0;
    collect("T2", 24, 0, 100, t);
    chk("T2 cycles c1..c27", 64'(t), 64'd27);
    chk("T2 done c28", 64'(done), 64'd1);
    tick();

    // T3: same run under random backpressure.
    start = 1'b1; num_passes = 8'd3;
    tick(); start = 1'b0;
    collect("T3", 24, 1, 400, t);
    wait_done("T3 done", 10);
    tick();

    // T4: ready low for 20 cycles, then two passes resume in order.
    start = 1'b1; num_passes = 8'd2; data_out_ready = 1'b0;
    tick(); start = 1'b0;
    collect("T4", 16, 2, 200, t);
    wait_done("T4 done", 10);
    tick();

    // T5: zero passes, done at c1, nothing else happens.
    start = 1'b1; num_passes = 8'd0; data_out_ready = 1'b1;
    tick(); start = 1'b0;                                      // c1
    chk("T5 done c1", 64'(done), 64'd1);
    chk("T5 busy c1", 64'(busy), 64'd0);
    chk("T5 valid c1", 64'(data_out_valid), 64'd0);
    tick();
    chk("T5 done c2", 64'(done), 64'd0);
    chk("T5 busy c2", 64'(busy), 64'd0);
    chk("T5 valid c2", 64'(data_out_valid), 64'd0);

    // T6: reset at beat 5, then a fresh run that ignores start while busy.
    start = 1'b1; num_passes = 8'd1;
    tick(); start = 1'b0;
    collect("T6a", 5, 0, 50, t);
    chk("T6 head before reset", 64'(data_out[0]), 64'd5);
    rst = 1'b1;
    tick();
    chk("T6 reset busy", 64'(busy), 64'd0);
    chk("T6 reset done", 64'(done), 64'd0);
    chk("T6 reset valid", 64'(data_out_valid), 64'd0);
    chk("T6 reset rom_addr", 64'(rom_addr), 64'd0);
    rst = 1'b0;
    tick();
    start = 1'b1; num_passes = 8'd1;                           // c0
    tick(); start = 1'b0;                                      // c1
    tick(); start = 1'b1; num_passes = 8'd3;                   // c2
    tick(); start = 1'b0;                                      // c3
    collect("T6b", 8, 0, 50, t);                               // ends c12
    chk("T6 done", 64'(done), 64'd1);
    start = 1'b1;
    tick(); start = 1'b0;
    chk("T6 start in DONE ignored", 64'(busy), 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("T6 idle valid %0d", i), 64'(data_out_valid), 64'd0);
      chk($sformatf("T6 idle busy %0d", i), 64'(busy), 64'd0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
